// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier operand stage.
// Holds the default operand width, product width, FSM states and counter width.
package mult_pkg;

  localparam int WIDTH  = 8;
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO carrying {m,q} operand pairs.
// Reads are combinational from the head entry.
module mult_op_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mult_operand_stage.sv
// Clocked operand/product stage around the combinational array multiplier.
// Define MULT_STAGE_CHECK_EN to add a sticky product self-check (check_err).
module mult_operand_stage
  import mult_pkg::*;
#(
  parameter int WIDTH         = mult_pkg::WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [15:0]        out_count,
`ifdef MULT_STAGE_CHECK_EN
  output logic               check_err,
`endif
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             pop;
  logic             load;
  logic             cap;
  logic             deliver;
  logic             push;
  logic             full;
  logic             empty;
  logic [PW-1:0]    head;

  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE) || !empty;

  mult_op_fifo #(
    .DW    (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_m, in_q}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    deliver = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          cap     = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          deliver = 1'b1;
          // Chain straight into the next pair to keep one product per settle window.
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            cnt_n   = CNT_LOAD;
            state_n = ST_SETTLE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mul_m       <= '0;
      mul_q       <= '0;
      out_product <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        mul_m <= head[PW-1:WIDTH];
        mul_q <= head[WIDTH-1:0];
      end
      if (cap) begin
        out_product <= mul_p;
        out_valid   <= 1'b1;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (deliver) out_count <= out_count + 16'd1;
    end
  end

`ifdef MULT_STAGE_CHECK_EN
  logic [PW-1:0] ref_p;

  assign ref_p = {{WIDTH{1'b0}}, mul_m} * {{WIDTH{1'b0}}, mul_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_err <= 1'b0;
    end else if (cap && (mul_p != ref_p)) begin
      check_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_operand_stage.sv
// Self-checking bench for mult_operand_stage with an attached array model.
// Covers latency, corner products, backpressure, reset, count wrap and self-check.
module tb_mult_operand_stage;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        bad = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [7:0]  in_m = '0;
  logic [7:0]  in_q = '0;
  logic [7:0]  mul_m;
  logic [7:0]  mul_q;
  logic [15:0] mul_p;
  logic [15:0] out_product;
  logic [15:0] out_count;
`ifdef MULT_STAGE_CHECK_EN
  logic        check_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  logic [15:0] cnt_exp = '0;
  logic        prev_hs = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_prod = '0;

  always #5 clk = ~clk;

  // Array model; "bad" corrupts the product to exercise the self-check.
  assign mul_p = bad ? 16'h0001 : {8'h00, mul_m} * {8'h00, mul_q};

  mult_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_m        (in_m),
    .in_q        (in_q),
    .mul_m       (mul_m),
    .mul_q       (mul_q),
    .mul_p       (mul_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_count   (out_count),
`ifdef MULT_STAGE_CHECK_EN
    .check_err   (check_err),
`endif
    .busy        (busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the accept edge.
  task automatic push(logic [7:0] m, logic [7:0] q, logic [15:0] p);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("push_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_m = m;
    in_q = q;
    sb.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", t < 200, 1);
    @(negedge clk);
  endtask

  // Scoreboard monitor, sampling just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_hs = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hs) chk("pulse", out_valid, 0);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_stable", out_product, prev_prod);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("product", out_product, sb.pop_front());
        chk("count", out_count, cnt_exp);
        cnt_exp = cnt_exp + 16'd1;
      end
      prev_hs = out_valid && out_ready;
      prev_hold = out_valid && !out_ready;
      prev_prod = out_product;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int   lat;
    tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[1] = '{8'h00, 8'hA5, 16'h0000};
    tbl[2] = '{8'h01, 8'h80, 16'h0080};
    tbl[3] = '{8'h80, 8'h80, 16'h4000};
    tbl[4] = '{8'hA5, 8'h5A, 16'h3A02};
    tbl[5] = '{8'h0C, 8'h0A, 16'h0078};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", out_count, 0);
    chk("rst_mul_m", mul_m, 0);
    chk("rst_product", out_product, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // Single op and latency
    push(8'h0C, 8'h0A, 16'h0078);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        chk("load_m", mul_m, 8'h0C);
        chk("load_q", mul_q, 8'h0A);
      end
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 3);
    @(negedge clk);
    drain();
    chk("count_single", out_count, 1);
    chk("mul_m_kept", mul_m, 8'h0C);

    // Corner values back-to-back
    for (int i = 0; i < 6; i++) push(tbl[i].m, tbl[i].q, tbl[i].p);
    drain();
    chk("count_table", out_count, 7);

    // Backpressure
    out_ready = 1'b0;
    push(8'h11, 8'h11, 16'h0121);
    push(8'h22, 8'h03, 16'h0066);
    push(8'h7F, 8'h02, 16'h00FE);
    repeat (6) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_product", out_product, 16'h0121);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    drain();
    chk("count_bp", out_count, 10);

    // Reset in SETTLE with two pairs buffered
    push(8'h33, 8'h33, 16'h0A29);
    push(8'h44, 8'h02, 16'h0088);
    push(8'h55, 8'h03, 16'h00FF);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_mul_m", mul_m, 0);
    chk("mid_rst_mul_q", mul_q, 0);
    chk("mid_rst_product", out_product, 0);
    sb.delete();
    cnt_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);

    // out_count wrap via preload
    force dut.out_count = 16'hFFFF;
    cnt_exp = 16'hFFFF;
    @(negedge clk);
    release dut.out_count;
    chk("preload", out_count, 16'hFFFF);
    push(8'h05, 8'h07, 16'h0023);
    drain();
    chk("wrap", out_count, 16'h0000);

`ifdef MULT_STAGE_CHECK_EN
    bad = 1'b1;
    push(8'h03, 8'h03, 16'h0001);
    drain();
    bad = 1'b0;
    chk("check_err_set", check_err, 1);
    push(8'h02, 8'h02, 16'h0004);
    drain();
    chk("check_err_sticky", check_err, 1);
    rst = 1'b1;
    #1;
    chk("check_err_rst", check_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
